// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle RV32I control path: opcodes, ALU op classes,
// controller states and the mux-select encodings driven around the datapath.
package multicycle_controller_pkg;

    typedef enum logic [6:0] {
        IType_load  = 7'b0000011,
        IType_logic = 7'b0010011,
        SType       = 7'b0100011,
        RType       = 7'b0110011,
        BType       = 7'b1100011,
        JType       = 7'b1101111
    } opcode_t;

    typedef enum logic [1:0] {
        MEMORY_ACCESS      = 2'b00,
        BRANCH             = 2'b01,
        REGISTER_OPERATION = 2'b10,
        ALU_OP__UNSET      = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RESULT_ALU_OUT  = 2'b00,
        RESULT_MEM_DATA = 2'b01,
        RESULT_ALU_LIVE = 2'b10
    } result_src_t;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives enables and mux selects around the datapath.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  opcode_t     opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output alu_src_a_t  alu_src_a,
    output alu_src_b_t  alu_src_b,
    output result_src_t result_src,
    output alu_op_t     alu_op,
    output logic        illegal_instr
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        mem_req_raw;
    logic        mem_write_raw;
    logic        ir_write_raw;
    logic        pc_write_raw;
    logic        reg_write_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FETCH;
            illegal_instr <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP)
                illegal_instr <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    IType_load, SType: state_next = S_MEMADR;
                    RType:             state_next = S_EXECUTER;
                    IType_logic:       state_next = S_EXECUTEI;
                    BType:             state_next = S_BEQ;
                    JType:             state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == IType_load)  state_next = S_MEMREAD;
                else if (opcode == SType)  state_next = S_MEMWRITE;
                else                       state_next = S_TRAP;
            end
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore decode of state; ir_write and the FETCH/BEQ pc_write look at live inputs.
    always_comb begin
        mem_req_raw   = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RESULT_ALU_OUT;
        alu_op        = ALU_OP__UNSET;
        case (state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RESULT_ALU_LIVE;
                alu_op       = MEMORY_ACCESS;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                alu_op    = MEMORY_ACCESS;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = MEMORY_ACCESS;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RESULT_MEM_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = REGISTER_OPERATION;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = REGISTER_OPERATION;
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_BEQ: begin
                alu_src_a    = SRC_A_RS1;
                alu_op       = BRANCH;
                pc_write_raw = zero;
            end
            S_JAL: begin
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_FOUR;
                alu_op       = MEMORY_ACCESS;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is asynchronous, so enables are masked combinationally to stop a
    // store or register write in the very cycle reset rises.
    assign mem_req   = mem_req_raw   & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign pc_write  = pc_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-derived values.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    opcode_t     opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    result_src_t result_src;
    alu_op_t     alu_op;
    logic        illegal_instr;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Control word: {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
    //                src_a[1:0], src_b[1:0], result_src[1:0], alu_op[1:0], illegal}
    logic [14:0] obs;
    assign obs = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};

    localparam logic [1:0] OP_MEM = 2'b00, OP_BR = 2'b01, OP_REG = 2'b10, OP_UNSET = 2'b11;

    function automatic logic [14:0] w(input logic mr, input logic as, input logic mw,
                                      input logic iw, input logic pw, input logic rw,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [1:0] op,
                                      input logic ill);
        return {mr, as, mw, iw, pw, rw, sa, sb, rs, op, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle mid-period, then move to just after the next edge.
    task automatic step(input string tag, input logic [14:0] exp);
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [14:0] fetch_go, fetch_wait, fetch_rst, decode_w, memadr_w, memread_w, memwb_w;
    logic [14:0] memwrite_w, execr_w, execi_w, aluwb_w, beq_t, beq_n, jal_w, trap_w;

    initial begin
        fetch_go   = w(1,0,0,1,1,0, 2'b00,2'b10,2'b10, OP_MEM,   0);
        fetch_wait = w(1,0,0,0,0,0, 2'b00,2'b10,2'b10, OP_MEM,   0);
        fetch_rst  = w(0,0,0,0,0,0, 2'b00,2'b10,2'b10, OP_MEM,   0);
        decode_w   = w(0,0,0,0,0,0, 2'b01,2'b01,2'b00, OP_MEM,   0);
        memadr_w   = w(0,0,0,0,0,0, 2'b10,2'b01,2'b00, OP_MEM,   0);
        memread_w  = w(1,1,0,0,0,0, 2'b00,2'b00,2'b00, OP_UNSET, 0);
        memwb_w    = w(0,0,0,0,0,1, 2'b00,2'b00,2'b01, OP_UNSET, 0);
        memwrite_w = w(1,1,1,0,0,0, 2'b00,2'b00,2'b00, OP_UNSET, 0);
        execr_w    = w(0,0,0,0,0,0, 2'b10,2'b00,2'b00, OP_REG,   0);
        execi_w    = w(0,0,0,0,0,0, 2'b10,2'b01,2'b00, OP_REG,   0);
        aluwb_w    = w(0,0,0,0,0,1, 2'b00,2'b00,2'b00, OP_UNSET, 0);
        beq_t      = w(0,0,0,0,1,0, 2'b10,2'b00,2'b00, OP_BR,    0);
        beq_n      = w(0,0,0,0,0,0, 2'b10,2'b00,2'b00, OP_BR,    0);
        jal_w      = w(0,0,0,0,1,0, 2'b01,2'b10,2'b00, OP_MEM,   0);
        trap_w     = w(0,0,0,0,0,0, 2'b00,2'b00,2'b00, OP_UNSET, 1);

        reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = opcode_t'(7'b0110011);
        @(negedge clk);
        check("reset_outputs", 32'(obs), 32'(fetch_rst));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // add: 4 cycles
        opcode = opcode_t'(7'b0110011);
        step("add_fetch", fetch_go);
        step("add_decode", decode_w);
        step("add_execr", execr_w);
        step("add_aluwb", aluwb_w);

        // addi through EXECUTEI
        opcode = opcode_t'(7'b0010011);
        step("addi_fetch", fetch_go);
        step("addi_decode", decode_w);
        step("addi_execi", execi_w);
        step("addi_aluwb", aluwb_w);

        // lw with two wait cycles in MEMREAD: 7 cycles total
        opcode = opcode_t'(7'b0000011);
        step("lw_fetch", fetch_go);
        step("lw_decode", decode_w);
        step("lw_memadr", memadr_w);
        mem_ready = 1'b0;
        step("lw_memread_w1", memread_w);
        step("lw_memread_w2", memread_w);
        mem_ready = 1'b1;
        step("lw_memread_go", memread_w);
        step("lw_memwb", memwb_w);

        // beq taken
        opcode = opcode_t'(7'b1100011); zero = 1'b1;
        step("beqt_fetch", fetch_go);
        step("beqt_decode", decode_w);
        step("beqt_beq", beq_t);

        // beq not taken, preceded by one fetch stall
        zero = 1'b0; mem_ready = 1'b0;
        step("beqn_fetch_stall", fetch_wait);
        mem_ready = 1'b1;
        step("beqn_fetch", fetch_go);
        step("beqn_decode", decode_w);
        step("beqn_beq", beq_n);

        // jal: JAL then ALUWB writes the link
        opcode = opcode_t'(7'b1101111);
        step("jal_fetch", fetch_go);
        step("jal_decode", decode_w);
        step("jal_jal", jal_w);
        step("jal_aluwb", aluwb_w);

        // sw stalled in MEMWRITE, aborted by asynchronous reset
        opcode = opcode_t'(7'b0100011);
        step("sw_fetch", fetch_go);
        step("sw_decode", decode_w);
        step("sw_memadr", memadr_w);
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_memwrite", 32'(obs), 32'(memwrite_w));
        #2 reset = 1'b1;
        #1 check("sw_reset_same_cycle", 32'(obs), 32'(fetch_rst));
        @(negedge clk);
        check("sw_reset_held", 32'(obs), 32'(fetch_rst));
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        step("post_reset_fetch", fetch_go);

        // illegal opcode traps and holds until reset
        opcode = opcode_t'(7'b0000000);
        step("trap_decode", decode_w);
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            step($sformatf("trap_hold_%0d", i), trap_w);
        end
        #2 reset = 1'b1;
        #1 check("trap_reset_clear", 32'(obs), 32'(fetch_rst));
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1; opcode = opcode_t'(7'b0110011);
        step("trap_exit_fetch", fetch_go);
        step("trap_exit_decode", decode_w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over several cycles, driving the write enables and mux selects around `Instruction_Decode`, the ALU, PC register and unified memory port. Supplies the `alu_op` that feeds `ALUdecoder`, and stalls on a single-cycle-ready memory handshake.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  opcode_t (7)  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag, valid in the BEQ cycle.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `adr_src`  out  1  0 = PC, 1 = ALU result register.
- `mem_write`  out  1  memory store enable.
- `ir_write`  out  1  latch instruction register and old PC.
- `pc_write`  out  1  PC register enable.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = imm_ext, 10 = constant 4.
- `result_src`  out  2  00 = ALU result register, 01 = memory data register, 10 = live ALU result.
- `alu_op`  out  alu_op_t  to `ALUdecoder`.
- `illegal_instr`  out  1  sticky flag; unsupported opcode decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Unlisted outputs in each state are 0, and `alu_op` is ALU_OP__UNSET.
- FETCH: `mem_req`=1, `adr_src`=0, src_a=00, src_b=10, `result_src`=10, `alu_op`=MEMORY_ACCESS. `ir_write` and `pc_write` assert only when `mem_ready`=1, then go to DECODE. Otherwise hold FETCH.
- DECODE: src_a=01, src_b=01, `alu_op`=MEMORY_ACCESS (branch/jump target precompute). Next state by opcode: IType_load/SType→MEMADR, RType→EXECUTER, IType_logic→EXECUTEI, BType→BEQ, JType→JAL, any other→TRAP.
- MEMADR: src_a=10, src_b=01, MEMORY_ACCESS. Next state: MEMREAD if load, MEMWRITE if store.
- MEMREAD: `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, then go to FETCH.
- MEMWRITE: `mem_req`=1, `adr_src`=1. `mem_write`=1 for every cycle in this state. Leave to FETCH on `mem_ready`.
- EXECUTER: src_a=10, src_b=00, REGISTER_OPERATION, then ALUWB.
- EXECUTEI: src_a=10, src_b=01, REGISTER_OPERATION, then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BEQ: src_a=10, src_b=00, BRANCH, `result_src`=00. `pc_write`=`zero`. Then FETCH.
- JAL: src_a=01, src_b=10, MEMORY_ACCESS, `result_src`=00, `pc_write`=1. Then ALUWB, which writes the link address.
- TRAP: absorbing, all enables 0, `illegal_instr`=1. Exit only via reset.

## Timing
- Reset (async assert) forces state FETCH and clears `illegal_instr`. While `reset`=1, `pc_write`, `ir_write`, `reg_write`, `mem_write` and `mem_req` are forced to 0. Select outputs show FETCH values.
- Outputs are Moore from state, except `pc_write` in FETCH/BEQ and `ir_write`, which are combinational on `mem_ready`/`zero`.
- Latency with zero-wait memory (`mem_ready` tied 1), in cycles: R/I-ALU 4, load 5, store 4, branch 3, jal 4.
- Each cycle of `mem_ready`=0 in FETCH/MEMREAD/MEMWRITE adds one cycle; no other state observes `mem_ready`.
- Reset mid-instruction aborts it; a store in progress has `mem_write` dropped in the same cycle reset asserts.
- `opcode` is only sampled in DECODE and MEMADR; the IR is stable then.

## Structure
- Add to `types.svh`: `ctrl_state_t` enum (4-bit), `alu_src_a_t`, `alu_src_b_t`, `result_src_t` typedefs with named encodings above. Reuse existing `opcode_t` and `alu_op_t`.
- Single module: state register plus next-state and output `always_comb` blocks. No sub-module.

## Test plan
- Zero-wait `add` (opcode 0110011): states FETCH→DECODE→EXECUTER→ALUWB→FETCH. `reg_write`=1 only in cycle 4. `alu_op`=REGISTER_OPERATION in cycle 3.
- `lw` (0000011) with `mem_ready` low 2 cycles in MEMREAD: MEMREAD lasts 3 cycles, `adr_src`=1 throughout, `reg_write` with `result_src`=01 in the following cycle. Total 7 cycles.
- `beq` (1100011): `zero`=1 gives `pc_write`=1 in BEQ. `zero`=0 gives `pc_write`=0. Both return to FETCH after 3 cycles.
- `jal` (1101111): `pc_write`=1 in JAL with src_a=01, src_b=10, then ALUWB `reg_write`=1.
- Opcode 0000000: DECODE→TRAP. `illegal_instr`=1 is held for 10+ cycles with all enables 0. Reset clears it and returns to FETCH.
- Assert `reset` asynchronously during MEMWRITE with `mem_ready`=0: `mem_write` falls the same cycle, state=FETCH, no enables while reset held.
